// File: rtl/alu_pkg.sv
// Shared constants for the four-unit ALU: data width, unit-select codes and opcodes.
package alu_pkg;

  localparam int WIDTH = 16;

  typedef enum logic [1:0] {
    UNIT_ARITH = 2'b00,
    UNIT_LOGIC = 2'b01,
    UNIT_CMP   = 2'b10,
    UNIT_SHIFT = 2'b11
  } unit_sel_e;

  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b0001;
  localparam logic [3:0] OP_MUL   = 4'b0010;
  localparam logic [3:0] OP_DIV   = 4'b0011;
  localparam logic [3:0] OP_AND   = 4'b0100;
  localparam logic [3:0] OP_OR    = 4'b0101;
  localparam logic [3:0] OP_NAND  = 4'b0110;
  localparam logic [3:0] OP_NOR   = 4'b0111;
  localparam logic [3:0] OP_CNOP  = 4'b1000;
  localparam logic [3:0] OP_CEQ   = 4'b1001;
  localparam logic [3:0] OP_CGT   = 4'b1010;
  localparam logic [3:0] OP_CLT   = 4'b1011;
  localparam logic [3:0] OP_SHRA  = 4'b1100;
  localparam logic [3:0] OP_SHLA  = 4'b1101;
  localparam logic [3:0] OP_SHRB  = 4'b1110;
  localparam logic [3:0] OP_SHLB  = 4'b1111;

endpackage

// File: rtl/alu_arith.sv
// Registered arithmetic unit: add, subtract, multiply, divide with carry/borrow flag.
module alu_arith
  import alu_pkg::*;
#(
  parameter int W = WIDTH
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [3:0]   fun,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] result,
  output logic         carry,
  output logic         flag
);

  logic [W-1:0]   result_d, result_q;
  logic           carry_d, carry_q;
  logic           flag_d, flag_q;
  logic [W:0]     sum;
  logic [W:0]     diff;
  logic [2*W-1:0] prod;

  always_comb begin
    sum      = {1'b0, a} + {1'b0, b};
    // Borrow shows up as the MSB of the wrapped (W+1)-bit difference.
    diff     = {1'b0, a} - {1'b0, b};
    prod     = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    result_d = '0;
    carry_d  = 1'b0;
    flag_d   = 1'b0;
    if (en) begin
      flag_d = 1'b1;
      case (fun)
        OP_ADD: {carry_d, result_d} = sum;
        OP_SUB: {carry_d, result_d} = diff;
        OP_MUL: begin
          result_d = prod[W-1:0];
          carry_d  = |prod[2*W-1:W];
        end
        OP_DIV: begin
          // Divide by zero yields zero rather than an undefined quotient.
          if (b != '0) result_d = a / b;
        end
        default: result_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
      carry_q  <= 1'b0;
      flag_q   <= 1'b0;
    end else begin
      result_q <= result_d;
      carry_q  <= carry_d;
      flag_q   <= flag_d;
    end
  end

  assign result = result_q;
  assign carry  = carry_q;
  assign flag   = flag_q;

endmodule

// File: rtl/alu_cmp.sv
// Registered compare unit: emits a small code for equal / greater / less tests.
module alu_cmp
  import alu_pkg::*;
#(
  parameter int W = WIDTH
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [3:0]   fun,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [3:0]   result,
  output logic         flag
);

  logic [3:0] result_d, result_q;
  logic       flag_d, flag_q;

  always_comb begin
    result_d = 4'd0;
    flag_d   = 1'b0;
    if (en) begin
      // Flag is raised for the no-op code too: the unit is still the selected one.
      flag_d = 1'b1;
      case (fun)
        OP_CNOP: result_d = 4'd0;
        OP_CEQ:  result_d = (a == b) ? 4'd1 : 4'd0;
        OP_CGT:  result_d = (a > b)  ? 4'd2 : 4'd0;
        OP_CLT:  result_d = (a < b)  ? 4'd3 : 4'd0;
        default: result_d = 4'd0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= 4'd0;
      flag_q   <= 1'b0;
    end else begin
      result_q <= result_d;
      flag_q   <= flag_d;
    end
  end

  assign result = result_q;
  assign flag   = flag_q;

endmodule

// File: rtl/alu_decoder.sv
// Combinational unit decoder: turns the unit-select field into a one-hot enable.
module alu_decoder
  import alu_pkg::*;
(
  input  logic [1:0] unit_sel,
  output logic [3:0] unit_en
);

  always_comb begin
    unit_en = 4'b0000;
    case (unit_sel_e'(unit_sel))
      UNIT_ARITH: unit_en = 4'b0001;
      UNIT_LOGIC: unit_en = 4'b0010;
      UNIT_CMP:   unit_en = 4'b0100;
      UNIT_SHIFT: unit_en = 4'b1000;
      default:    unit_en = 4'b0000;
    endcase
  end

endmodule

// File: rtl/alu_logic.sv
// Registered bitwise logic unit: and, or, nand, nor.
module alu_logic
  import alu_pkg::*;
#(
  parameter int W = WIDTH
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [3:0]   fun,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] result,
  output logic         flag
);

  logic [W-1:0] result_d, result_q;
  logic         flag_d, flag_q;

  always_comb begin
    result_d = '0;
    flag_d   = 1'b0;
    if (en) begin
      flag_d = 1'b1;
      case (fun)
        OP_AND:  result_d = a & b;
        OP_OR:   result_d = a | b;
        OP_NAND: result_d = ~(a & b);
        OP_NOR:  result_d = ~(a | b);
        default: result_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
      flag_q   <= 1'b0;
    end else begin
      result_q <= result_d;
      flag_q   <= flag_d;
    end
  end

  assign result = result_q;
  assign flag   = flag_q;

endmodule

// File: rtl/alu_shift.sv
// Registered shift unit: single-bit logical shifts of A or B with zero fill.
module alu_shift
  import alu_pkg::*;
#(
  parameter int W = WIDTH
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [3:0]   fun,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] result,
  output logic         flag
);

  logic [W-1:0] result_d, result_q;
  logic         flag_d, flag_q;

  always_comb begin
    result_d = '0;
    flag_d   = 1'b0;
    if (en) begin
      flag_d = 1'b1;
      case (fun)
        OP_SHRA: result_d = a >> 1;
        OP_SHLA: result_d = a << 1;
        OP_SHRB: result_d = b >> 1;
        OP_SHLB: result_d = b << 1;
        default: result_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
      flag_q   <= 1'b0;
    end else begin
      result_q <= result_d;
      flag_q   <= flag_d;
    end
  end

  assign result = result_q;
  assign flag   = flag_q;

endmodule

// File: rtl/alu_top.sv
// Four-unit registered ALU. No valid/ready handshake: each unit's Flag marks its result valid one edge after selection.
module alu_top
  import alu_pkg::*;
#(
  parameter int WIDTH = alu_pkg::WIDTH
) (
  input  logic             CLK,
  input  logic             RST_ARITH,
  input  logic             RST_LOGIC,
  input  logic             RST_CMP,
  input  logic             RST_SHIFT,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALU_FUN,
  output logic [WIDTH-1:0] Arith_OUT,
  output logic             Carry_OUT,
  output logic             Arith_Flag,
  output logic [WIDTH-1:0] Logic_OUT,
  output logic             Logic_Flag,
  output logic [3:0]       CMP_OUT,
  output logic             CMP_Flag,
  output logic [WIDTH-1:0] SHIFT_OUT,
  output logic             SHIFT_Flag
);

  logic [3:0] unit_en;

  alu_decoder u_dec (
    .unit_sel (ALU_FUN[3:2]),
    .unit_en  (unit_en)
  );

  alu_arith #(.W(WIDTH)) u_arith (
    .clk    (CLK),
    .rst_n  (RST_ARITH),
    .en     (unit_en[0]),
    .fun    (ALU_FUN),
    .a      (A),
    .b      (B),
    .result (Arith_OUT),
    .carry  (Carry_OUT),
    .flag   (Arith_Flag)
  );

  alu_logic #(.W(WIDTH)) u_logic (
    .clk    (CLK),
    .rst_n  (RST_LOGIC),
    .en     (unit_en[1]),
    .fun    (ALU_FUN),
    .a      (A),
    .b      (B),
    .result (Logic_OUT),
    .flag   (Logic_Flag)
  );

  alu_cmp #(.W(WIDTH)) u_cmp (
    .clk    (CLK),
    .rst_n  (RST_CMP),
    .en     (unit_en[2]),
    .fun    (ALU_FUN),
    .a      (A),
    .b      (B),
    .result (CMP_OUT),
    .flag   (CMP_Flag)
  );

  alu_shift #(.W(WIDTH)) u_shift (
    .clk    (CLK),
    .rst_n  (RST_SHIFT),
    .en     (unit_en[3]),
    .fun    (ALU_FUN),
    .a      (A),
    .b      (B),
    .result (SHIFT_OUT),
    .flag   (SHIFT_Flag)
  );

endmodule

// File: tb/tb_alu_top.sv
// Directed bench for alu_top: hand-computed vectors checked with immediate assertions.
module tb_alu_top;

  logic        clk;
  logic        rst_arith, rst_logic, rst_cmp, rst_shift;
  logic [15:0] a, b;
  logic [3:0]  alu_fun;
  logic [15:0] arith_out, logic_out, shift_out;
  logic        carry_out, arith_flag, logic_flag, cmp_flag, shift_flag;
  logic [3:0]  cmp_out;

  int checks;
  int failures;

  alu_top dut (
    .CLK        (clk),
    .RST_ARITH  (rst_arith),
    .RST_LOGIC  (rst_logic),
    .RST_CMP    (rst_cmp),
    .RST_SHIFT  (rst_shift),
    .A          (a),
    .B          (b),
    .ALU_FUN    (alu_fun),
    .Arith_OUT  (arith_out),
    .Carry_OUT  (carry_out),
    .Arith_Flag (arith_flag),
    .Logic_OUT  (logic_out),
    .Logic_Flag (logic_flag),
    .CMP_OUT    (cmp_out),
    .CMP_Flag   (cmp_flag),
    .SHIFT_OUT  (shift_out),
    .SHIFT_Flag (shift_flag)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver: apply operands/opcode, then sample 1 time unit after the next rising edge
  task automatic do_op(input logic [15:0] op_a, input logic [15:0] op_b, input logic [3:0] fun);
    a       = op_a;
    b       = op_b;
    alu_fun = fun;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_arith(input string tag, input logic [15:0] res, input logic c, input logic f);
    chk({tag, "_out"}, arith_out, res);
    chk({tag, "_carry"}, {15'd0, carry_out}, {15'd0, c});
    chk({tag, "_flag"}, {15'd0, arith_flag}, {15'd0, f});
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst_arith = 1'b0;
    rst_logic = 1'b0;
    rst_cmp   = 1'b0;
    rst_shift = 1'b0;
    a         = 16'd0;
    b         = 16'd0;
    alu_fun   = 4'b0000;
    #2;
    chk_arith("rst_arith", 16'd0, 1'b0, 1'b0);
    chk("rst_logic", logic_out, 16'd0);
    chk("rst_cmp", {12'd0, cmp_out}, 16'd0);
    chk("rst_shift", shift_out, 16'd0);
    chk("rst_flags", {12'd0, logic_flag, cmp_flag, shift_flag, 1'b0}, 16'd0);
    @(posedge clk);
    #2;
    rst_arith = 1'b1;
    rst_logic = 1'b1;
    rst_cmp   = 1'b1;
    rst_shift = 1'b1;

    // arithmetic
    do_op(16'd3, 16'd2, 4'b0000);      chk_arith("add", 16'd5, 1'b0, 1'b1);
    do_op(16'd3, 16'd2, 4'b0001);      chk_arith("sub", 16'd1, 1'b0, 1'b1);
    do_op(16'd3, 16'd2, 4'b0010);      chk_arith("mul", 16'd6, 1'b0, 1'b1);
    do_op(16'd3, 16'd2, 4'b0011);      chk_arith("div", 16'd1, 1'b0, 1'b1);
    do_op(16'hFFFF, 16'd1, 4'b0000);   chk_arith("add_ovf", 16'd0, 1'b1, 1'b1);
    do_op(16'd2, 16'd3, 4'b0001);      chk_arith("sub_borrow", 16'hFFFF, 1'b1, 1'b1);
    do_op(16'h0100, 16'h0100, 4'b0010); chk_arith("mul_ovf", 16'd0, 1'b1, 1'b1);
    do_op(16'd7, 16'd2, 4'b0011);      chk_arith("div_trunc", 16'd3, 1'b0, 1'b1);
    do_op(16'd9, 16'd0, 4'b0011);      chk_arith("div_zero", 16'd0, 1'b0, 1'b1);

    // logic
    do_op(16'd3, 16'd2, 4'b0100);
    chk("and", logic_out, 16'h0002);
    chk("and_flag", {15'd0, logic_flag}, 16'd1);
    chk_arith("arith_idle", 16'd0, 1'b0, 1'b0);
    do_op(16'd3, 16'd2, 4'b0101);      chk("or", logic_out, 16'h0003);
    do_op(16'd3, 16'd2, 4'b0110);      chk("nand", logic_out, 16'hFFFD);
    do_op(16'd3, 16'd2, 4'b0111);      chk("nor", logic_out, 16'hFFFC);

    // compare
    do_op(16'd3, 16'd3, 4'b1001);
    chk("ceq", {12'd0, cmp_out}, 16'd1);
    chk("logic_idle", logic_out, 16'd0);
    do_op(16'd3, 16'd2, 4'b1010);      chk("cgt", {12'd0, cmp_out}, 16'd2);
    do_op(16'd2, 16'd3, 4'b1011);      chk("clt", {12'd0, cmp_out}, 16'd3);
    do_op(16'd3, 16'd2, 4'b1000);
    chk("cnop", {12'd0, cmp_out}, 16'd0);
    chk("cnop_flag", {15'd0, cmp_flag}, 16'd1);
    do_op(16'd3, 16'd2, 4'b1001);      chk("ceq_ne", {12'd0, cmp_out}, 16'd0);
    do_op(16'd2, 16'd3, 4'b1010);      chk("cgt_false", {12'd0, cmp_out}, 16'd0);

    // shift
    do_op(16'd2, 16'd0, 4'b1100);
    chk("shra", shift_out, 16'd1);
    chk("shra_flag", {15'd0, shift_flag}, 16'd1);
    do_op(16'd2, 16'd0, 4'b1101);      chk("shla", shift_out, 16'd4);
    do_op(16'd0, 16'd2, 4'b1110);      chk("shrb", shift_out, 16'd1);
    do_op(16'd0, 16'd2, 4'b1111);      chk("shlb", shift_out, 16'd4);
    do_op(16'h8000, 16'd0, 4'b1101);   chk("shla_msb", shift_out, 16'd0);

    // enable isolation: shift -> compare nop
    do_op(16'd2, 16'd0, 4'b1100);
    do_op(16'd2, 16'd0, 4'b1000);
    chk("iso_shift_out", shift_out, 16'd0);
    chk("iso_flags", {12'd0, arith_flag, logic_flag, cmp_flag, shift_flag}, 16'b0010);
    chk("iso_logic", logic_out, 16'd0);
    chk("iso_arith", arith_out, 16'd0);

    // arithmetic reset mid-cycle
    do_op(16'd3, 16'd2, 4'b0000);
    chk_arith("pre_rst_add", 16'd5, 1'b0, 1'b1);
    #2 rst_arith = 1'b0;
    #1 chk_arith("rst_arith_async", 16'd0, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk_arith("rst_arith_hold", 16'd0, 1'b0, 1'b0);
    rst_arith = 1'b1;

    // logic reset
    do_op(16'd3, 16'd2, 4'b0100);
    chk("pre_rst_and", logic_out, 16'h0002);
    #2 rst_logic = 1'b0;
    #1 chk("rst_logic_async", {logic_out[14:0], logic_flag}, 16'd0);
    @(posedge clk); #1;
    chk("rst_logic_hold", {logic_out[14:0], logic_flag}, 16'd0);
    rst_logic = 1'b1;

    // compare reset
    do_op(16'd3, 16'd3, 4'b1001);
    chk("pre_rst_ceq", {12'd0, cmp_out}, 16'd1);
    #2 rst_cmp = 1'b0;
    #1 chk("rst_cmp_async", {11'd0, cmp_out, cmp_flag}, 16'd0);
    @(posedge clk); #1;
    chk("rst_cmp_hold", {11'd0, cmp_out, cmp_flag}, 16'd0);
    rst_cmp = 1'b1;

    // shift reset, plus arithmetic reset must not disturb the shift unit
    do_op(16'd0, 16'd2, 4'b1110);
    chk("pre_rst_shrb", shift_out, 16'd1);
    #2 rst_arith = 1'b0;
    #1 chk("rst_other_shift", shift_out, 16'd1);
    chk("rst_other_flag", {15'd0, shift_flag}, 16'd1);
    rst_arith = 1'b1;
    rst_shift = 1'b0;
    #1 chk("rst_shift_async", {shift_out[14:0], shift_flag}, 16'd0);
    @(posedge clk); #1;
    chk("rst_shift_hold", {shift_out[14:0], shift_flag}, 16'd0);
    rst_shift = 1'b1;

    // units recover after reset release
    do_op(16'd3, 16'd2, 4'b0000);
    chk_arith("post_rst_add", 16'd5, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
